// File: rtl/tsconf_uart_pkg.sv
// Shared types and constants for the tsconf serial receive path.
package tsconf_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // 84 MHz / (31250 baud * 16 oversample)
  localparam int unsigned MIDI_BAUD_DIV = 168;
  localparam int unsigned MIDI_OVS      = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO: head is visible on head_o whenever the FIFO is not empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage array; contents are masked by empty_o so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver with 16x oversampling, majority voting and a show-ahead byte FIFO.
module midi_uart_rx
  import tsconf_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = MIDI_BAUD_DIV,
  parameter int unsigned OVS        = MIDI_OVS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SW = $clog2(OVS);

  localparam logic [TW-1:0] TickLast = TW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] SmpLo    = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SmpMid   = SW'(OVS / 2);
  localparam logic [SW-1:0] SmpHi    = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] SmpLast  = SW'(OVS - 1);

  logic          rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    vote_q, vote_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          tick, maj, push, set_ferr;
  logic          fifo_empty, fifo_full, fifo_drop;

  // Synchroniser, edge history and all FSM/datapath state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= StIdle;
      tick_q      <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      vote_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      vote_q      <= vote_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Oversample timing, bit voting and frame sequencing.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    smp_d    = smp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    vote_d   = vote_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    tick     = (state_q != StIdle) && (tick_q == TickLast);
    // Third vote is the live sample taken at SmpHi.
    maj      = maj3(vote_q[0], vote_q[1], rxs_q);

    if (state_q != StIdle) tick_d = tick ? '0 : tick_q + TW'(1);
    if (tick) begin
      smp_d = (smp_q == SmpLast) ? '0 : smp_q + SW'(1);
      if (smp_q == SmpLo)  vote_d[0] = rxs_q;
      if (smp_q == SmpMid) vote_d[1] = rxs_q;
    end

    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = StStart;
          tick_d  = '0;
          smp_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (smp_q == SmpHi && maj) begin
            state_d = StIdle;
          end else if (smp_q == SmpLast) begin
            state_d = StData;
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (smp_q == SmpHi) shift_d = {maj, shift_q[7:1]};
          if (smp_q == SmpLast) begin
            if (bit_q == 3'd7) state_d = StStop;
            else               bit_d   = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        // Decide at mid stop bit so a following start edge is never missed.
        if (tick && smp_q == SmpHi) begin
          if (maj) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            set_ferr = 1'b1;
            state_d  = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Sticky flags: a set event beats a simultaneous clear.
    frame_err_d = set_ferr  | (frame_err_q & ~clr_err);
    overrun_d   = fifo_drop | (overrun_q & ~clr_err);
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_en),
    .head_o  (rd_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop)
  );

  assign rd_valid  = ~fifo_empty;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench: a full-rate receiver for the real baud rate and a fast one for the long scenarios.
module tb_midi_uart_rx;

  localparam int unsigned FastDiv = 12;
  localparam int SlowBit = 168 * 16;
  localparam int FastBit = FastDiv * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_s = 1'b1;
  logic       rx_f = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data_s, rd_data_f;
  logic       rd_valid_s, rd_valid_f, busy_s, busy_f;
  logic       frame_err_s, frame_err_f, overrun_s, overrun_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  midi_uart_rx u_dut_slow (
    .clk_sys   (clk),
    .reset     (reset),
    .rx        (rx_s),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data_s),
    .rd_valid  (rd_valid_s),
    .busy      (busy_s),
    .frame_err (frame_err_s),
    .overrun   (overrun_s)
  );

  midi_uart_rx #(
    .BAUD_DIV   (FastDiv),
    .OVS        (16),
    .FIFO_DEPTH (4)
  ) u_dut_fast (
    .clk_sys   (clk),
    .reset     (reset),
    .rx        (rx_f),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data_f),
    .rd_valid  (rd_valid_f),
    .busy      (busy_f),
    .frame_err (frame_err_f),
    .overrun   (overrun_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus changes and samples happen on falling edges.
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit slow, input logic v);
    if (slow) rx_s = v;
    else      rx_f = v;
  endtask

  task automatic send_frame(input bit slow, input logic [7:0] b, input int bit_clks,
                            input logic stop_v, input int stop_clks);
    set_rx(slow, 1'b0);
    wait_clk(bit_clks);
    for (int i = 0; i < 8; i++) begin
      set_rx(slow, b[i]);
      wait_clk(bit_clks);
    end
    set_rx(slow, stop_v);
    wait_clk(stop_clks);
    set_rx(slow, 1'b1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, rd_valid_f, 1);
    check_eq({tag, "_data"}, rd_data_f, exp);
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int k;
    logic [7:0] b;

    wait_clk(3);
    check_eq("rst_valid", rd_valid_f, 0);
    check_eq("rst_data", rd_data_f, 0);
    check_eq("rst_busy", busy_f, 0);
    check_eq("rst_ferr", frame_err_f, 0);
    check_eq("rst_ovr", overrun_f, 0);
    reset = 1'b0;
    wait_clk(5);

    // 0x55 at real MIDI rate.
    send_frame(1'b1, 8'h55, SlowBit, 1'b1, SlowBit);
    k = 0;
    while (busy_s && k < 5000) begin
      wait_clk(1);
      k++;
    end
    check_eq("slow_busy_fall", busy_s, 0);
    check_eq("slow_valid", rd_valid_s, 1);
    check_eq("slow_data", rd_data_s, 8'h55);
    check_eq("slow_ferr", frame_err_s, 0);
    check_eq("slow_ovr", overrun_s, 0);
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
    check_eq("slow_pop_empty", rd_valid_s, 0);

    // 40-clock low glitch on an idle line is rejected.
    rx_s = 1'b0;
    rx_f = 1'b0;
    wait_clk(40);
    rx_s = 1'b1;
    rx_f = 1'b1;
    wait_clk(2000);
    check_eq("glitch_valid", rd_valid_s, 0);
    check_eq("glitch_ferr", frame_err_s, 0);
    check_eq("glitch_busy", busy_s, 0);
    check_eq("glitch_f_valid", rd_valid_f, 0);
    check_eq("glitch_f_ferr", frame_err_f, 0);

    // Stop bit held low for two bit times: framing error, byte dropped.
    send_frame(1'b0, 8'hA3, FastBit, 1'b0, 2 * FastBit);
    wait_clk(20);
    check_eq("brk_ferr", frame_err_f, 1);
    check_eq("brk_valid", rd_valid_f, 0);
    check_eq("brk_busy", busy_f, 0);
    pulse_clr();
    check_eq("brk_clr", frame_err_f, 0);
    send_frame(1'b0, 8'h3C, FastBit, 1'b1, FastBit);
    wait_clk(10);
    pop_check("after_brk", 8'h3C);
    check_eq("after_brk_ferr", frame_err_f, 0);

    // Five back-to-back bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(1'b0, b, FastBit, 1'b1, FastBit);
    end
    wait_clk(10);
    check_eq("ovr_set", overrun_f, 1);
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      pop_check($sformatf("ovr_pop%0d", i), b);
    end
    check_eq("ovr_drained", rd_valid_f, 0);
    pulse_clr();
    check_eq("ovr_clr", overrun_f, 0);

    // Fill, then pop on the exact edge that pushes 0x99.
    send_frame(1'b0, 8'h11, FastBit, 1'b1, FastBit);
    send_frame(1'b0, 8'h22, FastBit, 1'b1, FastBit);
    send_frame(1'b0, 8'h33, FastBit, 1'b1, FastBit);
    send_frame(1'b0, 8'h44, FastBit, 1'b1, FastBit);
    // Start edge seen 3 edges after rx falls; stop-bit vote lands 12*10 + 192*9 edges later.
    fork
      send_frame(1'b0, 8'h99, FastBit, 1'b1, FastBit);
      begin
        wait_clk(3 + 12 * 10 + FastBit * 9 - 1);
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
      end
    join
    wait_clk(10);
    check_eq("pp_ovr", overrun_f, 0);
    pop_check("pp_pop0", 8'h22);
    pop_check("pp_pop1", 8'h33);
    pop_check("pp_pop2", 8'h44);
    pop_check("pp_pop3", 8'h99);
    check_eq("pp_drained", rd_valid_f, 0);

    // Reset in the middle of 0xF0 with a byte already queued.
    send_frame(1'b0, 8'h77, FastBit, 1'b1, FastBit);
    wait_clk(10);
    check_eq("pre_rst_valid", rd_valid_f, 1);
    rx_f = 1'b0;
    wait_clk(3 * FastBit);
    check_eq("mid_frame_busy", busy_f, 1);
    reset = 1'b1;
    rx_f = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(FastBit);
    check_eq("mid_rst_valid", rd_valid_f, 0);
    check_eq("mid_rst_data", rd_data_f, 0);
    check_eq("mid_rst_busy", busy_f, 0);
    check_eq("mid_rst_ferr", frame_err_f, 0);
    check_eq("mid_rst_ovr", overrun_f, 0);
    send_frame(1'b0, 8'h12, FastBit, 1'b1, FastBit);
    wait_clk(10);
    pop_check("post_rst", 8'h12);
    check_eq("post_rst_ferr", frame_err_f, 0);

    // +3% and -3% bit-period skew.
    send_frame(1'b0, 8'h5A, 198, 1'b1, 198);
    wait_clk(50);
    pop_check("skew_slow", 8'h5A);
    send_frame(1'b0, 8'h5A, 186, 1'b1, 186);
    wait_clk(50);
    pop_check("skew_fast", 8'h5A);
    check_eq("skew_ferr", frame_err_f, 0);
    check_eq("skew_empty", rd_valid_f, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
